// File: rtl/neurosync_round_sequencer.sv
// neurosync_round_sequencer: replays one NeuroSync round on the LEDs, then checks the player's presses
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   start_round_i        pulse, accepted only in IDLE; latches round_len_i
//   abort_i              synchronous abort to IDLE, suppresses any result pulse
//   round_len_i          last step index of the round
//   mem_data_i           one-hot step from sequence memory (valid the cycle after mem_addr_o)
//   botoes_i             synchronised player buttons
//   mem_addr_o           registered memory read address
//   leds_o               registered LED drive
//   busy_o               high whenever the state is not IDLE
//   rodada_ok_o/erro_o/timeout_o  one-cycle result pulses, asserted while in RESULT
//   db_estado_o          current state encoding
//
// Optional feature: define NEUROSYNC_INPUT_ECHO_EN to echo botoes_i on the LEDs during WAIT_PLAY.
module neurosync_round_sequencer #(
  parameter int ADDR_W         = 4,
  parameter int ON_CYCLES      = 1000,
  parameter int OFF_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_round_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] round_len_i,
  input  logic [3:0]        mem_data_i,
  input  logic [3:0]        botoes_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        leds_o,
  output logic              busy_o,
  output logic              rodada_ok_o,
  output logic              erro_o,
  output logic              timeout_o,
  output logic [3:0]        db_estado_o
);
  localparam int MAX_SHOW = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CNT  = MAX_SHOW > TIMEOUT_CYCLES ? MAX_SHOW : TIMEOUT_CYCLES;
  localparam int CW       = MAX_CNT > 1 ? $clog2(MAX_CNT) : 1;
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_LOAD    = 4'd2;
  localparam logic [3:0] SHOW_ON   = 4'd3;
  localparam logic [3:0] SHOW_OFF  = 4'd4;
  localparam logic [3:0] P_FETCH   = 4'd5;
  localparam logic [3:0] P_LOAD    = 4'd6;
  localparam logic [3:0] WAIT_PLAY = 4'd7;
  localparam logic [3:0] RESULT    = 4'd8;
  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, len_q, len_d;
  logic [3:0]        step_q, step_d, leds_q, leds_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ok_q, ok_d, err_q, err_d, to_q, to_d, armed_q, armed_d;
  logic              press;
  // A press is taken only on a fresh edge: armed drops on acceptance and
  // re-arms after any cycle with all buttons released, so held buttons never
  // count twice and presses carried over from a previous round are ignored.
  assign press = state_q == WAIT_PLAY && armed_q && botoes_i != 4'd0;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    armed_d = press ? 1'b0 : botoes_i == 4'd0 ? 1'b1 : armed_q;
    case (state_q)
      IDLE: if (start_round_i) begin
        state_d = S_FETCH;
        addr_d  = '0;
        len_d   = round_len_i;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        step_d  = mem_data_i;
        cnt_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: if (cnt_q == CW'(ON_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = SHOW_OFF;
      end else cnt_d = cnt_q + CW'(1);
      SHOW_OFF: if (cnt_q == CW'(OFF_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = addr_q < len_q ? S_FETCH : P_FETCH;
        addr_d  = addr_q < len_q ? addr_q + ADDR_W'(1) : '0;
      end else cnt_d = cnt_q + CW'(1);
      P_FETCH: state_d = P_LOAD;
      P_LOAD: begin
        step_d  = mem_data_i;
        cnt_d   = '0;
        state_d = WAIT_PLAY;
      end
      WAIT_PLAY: begin
        // An accepted press is evaluated before the timeout, so a press on
        // the final timeout cycle still counts.
        if (press) begin
          if (botoes_i != step_q) begin
            err_d   = 1'b1;
            state_d = RESULT;
          end else if (addr_q == len_q) begin
            ok_d    = 1'b1;
            state_d = RESULT;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = P_FETCH;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = RESULT;
        end else cnt_d = cnt_q + CW'(1);
      end
      RESULT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      to_d    = 1'b0;
    end
`ifdef NEUROSYNC_INPUT_ECHO_EN
    leds_d = state_d == SHOW_ON ? step_d : (state_q == WAIT_PLAY && !abort_i) ? botoes_i : 4'd0;
`else
    leds_d = state_d == SHOW_ON ? step_d : 4'd0;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      leds_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      to_q    <= to_d;
      armed_q <= armed_d;
    end
  end
  assign mem_addr_o  = addr_q;
  assign leds_o      = leds_q;
  assign busy_o      = state_q != IDLE;
  assign rodada_ok_o = ok_q;
  assign erro_o      = err_q;
  assign timeout_o   = to_q;
  assign db_estado_o = state_q;
endmodule

// File: tb/tb_neurosync_round_sequencer.sv
// tb_neurosync_round_sequencer: randomized rounds checked against a per-cycle expected timeline
module tb_neurosync_round_sequencer;
  localparam int AW = 4, ON = 4, OFF = 2, TO = 20, P = 2 + ON + OFF, N = 1024;
  logic clk = 1'b0, rst_n = 1'b0, start_round = 1'b0, abort = 1'b0;
  logic [AW-1:0] round_len = '0, mem_addr;
  logic [3:0] mem_data, botoes = 4'd0, leds, db_estado;
  logic busy, rodada_ok, erro, timeout;
  logic [3:0] mem [16];
  int checks = 0, errors = 0;
  logic [3:0] bot_s [N];
  logic [AW-1:0] len_s [N];
  logic st_s [N], ab_s [N], inw [N];
  logic [3:0] e_leds [N];
  logic e_busy [N], e_ok [N], e_err [N], e_to [N];
  int e_db [N], e_addr [N];
  neurosync_round_sequencer #(.ADDR_W(AW), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_round_i(start_round), .abort_i(abort),
    .round_len_i(round_len), .mem_data_i(mem_data), .botoes_i(botoes),
    .mem_addr_o(mem_addr), .leds_o(leds), .busy_o(busy), .rodada_ok_o(rodada_ok),
    .erro_o(erro), .timeout_o(timeout), .db_estado_o(db_estado)
  );
  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem[mem_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_cycle(input int c, input int k);
    inw[c] = 1'b1;
    e_busy[c] = 1'b1;
    e_db[c] = 7;
    e_addr[c] = k;
  endtask
  // mode 0: random outcome, 1: every press correct, 2: random outcome plus an abort
  task automatic run_round(input int len, input int mode);
    int w, k, jmin, d, h, r, act, a, last, ncyc;
    logic [3:0] v;
    bit done;
    for (int c = 0; c < N; c++) begin
      bot_s[c] = 4'd0; st_s[c] = 1'b0; ab_s[c] = 1'b0; inw[c] = 1'b0; len_s[c] = AW'($urandom);
      e_leds[c] = 4'd0; e_busy[c] = 1'b0; e_ok[c] = 1'b0; e_err[c] = 1'b0; e_to[c] = 1'b0;
      e_db[c] = -1; e_addr[c] = -1;
    end
    st_s[0] = 1'b1; len_s[0] = AW'(len); e_db[0] = 0;
    for (int c = 1; c <= (len + 1) * P; c++) begin
      e_busy[c] = 1'b1;
      e_addr[c] = (c - 1) / P;
      e_leds[c] = ((c - 1) % P >= 2 && (c - 1) % P < 2 + ON) ? mem[(c - 1) / P] : 4'd0;
    end
    w = (len + 1) * P + 3; k = 0; jmin = 0; done = 0; last = 0; r = 0;
    e_busy[w-2] = 1'b1; e_busy[w-1] = 1'b1; e_addr[w-2] = 0; e_addr[w-1] = 0;
    while (!done) begin
      act = mode == 1 ? $urandom_range(2, 9) : $urandom_range(0, 9);
      if (act == 0) begin
        for (int j = 0; j < TO; j++) wait_cycle(w + j, k);
        r = w + TO; e_to[r] = 1'b1; done = 1;
      end else begin
        d = act == 2 ? TO - 1 : jmin + $urandom_range(0, 6);
        v = mem[k];
        if (act == 1) do v = 4'($urandom_range(1, 15)); while (v == mem[k]);
        h = $urandom_range(1, 6);
        for (int j = 0; j <= d; j++) wait_cycle(w + j, k);
        for (int i = 0; i < h; i++) bot_s[w+d+i] = v;
        last = w + d + h;
        if (act != 1 && k < len) begin
          e_busy[w+d+1] = 1'b1; e_busy[w+d+2] = 1'b1;
          e_addr[w+d+1] = k + 1; e_addr[w+d+2] = k + 1;
          w = w + d + 3; k++;
          jmin = h > 2 ? h - 2 : 0;
        end else begin
          r = w + d + 1;
          if (act == 1) e_err[r] = 1'b1; else e_ok[r] = 1'b1;
          done = 1;
        end
      end
    end
    e_busy[r] = 1'b1; e_db[r] = 8; e_addr[r] = k;
    ncyc = (last > r ? last : r) + 3;
    for (int c = r + 1; c < ncyc; c++) e_db[c] = 0;
    for (int c = 1; c <= r; c++) if ($urandom_range(0, 15) == 0) st_s[c] = 1'b1;
`ifdef NEUROSYNC_INPUT_ECHO_EN
    for (int c = 1; c < ncyc; c++) if (inw[c-1]) e_leds[c] = bot_s[c-1];
`endif
    if (mode == 2) begin
      a = $urandom_range(1, r);
      ab_s[a] = 1'b1;
      for (int c = a + 1; c < ncyc; c++) begin
        e_leds[c] = 4'd0; e_busy[c] = 1'b0; e_ok[c] = 1'b0; e_err[c] = 1'b0; e_to[c] = 1'b0;
        e_db[c] = 0; e_addr[c] = -1; st_s[c] = 1'b0;
      end
    end
    for (int c = 0; c < ncyc; c++) begin
      start_round = st_s[c]; abort = ab_s[c]; round_len = len_s[c]; botoes = bot_s[c];
      @(negedge clk);
      check($sformatf("leds len%0d c%0d", len, c), 32'(leds), 32'(e_leds[c]));
      check($sformatf("busy len%0d c%0d", len, c), 32'(busy), 32'(e_busy[c]));
      check($sformatf("rodada_ok len%0d c%0d", len, c), 32'(rodada_ok), 32'(e_ok[c]));
      check($sformatf("erro len%0d c%0d", len, c), 32'(erro), 32'(e_err[c]));
      check($sformatf("timeout len%0d c%0d", len, c), 32'(timeout), 32'(e_to[c]));
      if (e_db[c] >= 0) check($sformatf("db_estado len%0d c%0d", len, c), 32'(db_estado), 32'(e_db[c]));
      if (e_addr[c] >= 0) check($sformatf("mem_addr len%0d c%0d", len, c), 32'(mem_addr), 32'(e_addr[c]));
      @(posedge clk); #1;
    end
    start_round = 1'b0; abort = 1'b0; botoes = 4'd0;
  endtask
  initial begin
    mem[0] = 4'b0001; mem[1] = 4'b1000; mem[2] = 4'b0100;
    for (int i = 3; i < 16; i++) mem[i] = 4'b0001 << $urandom_range(0, 3);
    repeat (3) @(posedge clk);
    #1;
    check("reset leds", 32'(leds), 0);
    check("reset busy", 32'(busy), 0);
    check("reset db_estado", 32'(db_estado), 0);
    check("reset mem_addr", 32'(mem_addr), 0);
    check("reset pulses", {29'd0, rodada_ok, erro, timeout}, 0);
    rst_n = 1'b1;
    start_round = 1'b1; round_len = AW'(2);
    @(posedge clk); #1;
    start_round = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre-reset show leds", 32'(leds), 32'(mem[0]));
    check("pre-reset show state", 32'(db_estado), 3);
    rst_n = 1'b0;
    #1;
    check("async reset leds", 32'(leds), 0);
    check("async reset busy", 32'(busy), 0);
    check("async reset db_estado", 32'(db_estado), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_round(2, 1);
    run_round(1, 0);
    run_round(15, 1);
    run_round(0, 1);
    run_round(3, 2);
    for (int i = 0; i < 40; i++) run_round($urandom_range(0, 15), $urandom_range(0, 2));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
